// File: rtl/adc_capture_sequencer_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding, counter width
// and the saturating-increment helper used by the statistics counters.
package adc_capture_sequencer_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FAULT   = 2'd3
  } seq_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Valid/ready word stream from the capture sequencer to the entropy FIFO.
interface adc_capture_sequencer_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/adc_capture_sequencer_bit_packer.sv
// Shift accumulator packing P_BITS-wide fragments MSB-first into P_WORD_W words;
// the completed word is presented combinationally in the cycle its last fragment arrives.
module adc_bit_packer #(
  parameter int unsigned P_BITS   = 2,
  parameter int unsigned P_WORD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [P_BITS-1:0]   bits,
  input  logic                bits_vld,
  input  logic                flush,
  output logic [P_WORD_W-1:0] word,
  output logic                word_vld
);

  localparam int unsigned N  = P_WORD_W / P_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  logic [P_WORD_W-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last;

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    word     = (acc_q << P_BITS) | P_WORD_W'(bits);
    word_vld = bits_vld && !flush && last;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bits_vld) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = word;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// ADC acquisition sequencer: warm-up discard, over-range supervision, LSB packing onto a
// valid/ready stream. Define ADC_XOR_WHITEN_EN to XOR the next-higher bit group into the LSBs.
module adc_capture_sequencer
  import adc_capture_sequencer_pkg::*;
#(
  parameter int unsigned P_BITS_PER_SAMPLE = 2,
  parameter int unsigned P_WORD_W          = 32,
  parameter int unsigned P_WARMUP          = 64,
  parameter int unsigned P_OR_LIMIT        = 8
) (
  input  logic                    AD_CLK_P_SYS,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [13:0]             adc_data,
  input  logic                    adc_or,
  output logic                    adc_oe_n,
  adc_capture_sequencer_if.master m,
  output logic                    busy,
  output logic                    fault,
  output logic [CNT_W-1:0]        or_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int unsigned B  = P_BITS_PER_SAMPLE;
  localparam int unsigned WW = $clog2(P_WARMUP + 1);
  localparam int unsigned OW = $clog2(P_OR_LIMIT + 1);

  seq_state_e          state_q, state_d;
  logic [13:0]         adc_q;
  logic                or_q;
  logic [WW-1:0]       warm_cnt_q;
  logic [OW-1:0]       consec_q;
  logic [CNT_W-1:0]    or_count_q, drop_count_q;
  logic [P_WORD_W-1:0] m_data_q;
  logic                m_valid_q;

  logic [B-1:0]        bits;
  logic                bits_vld, flush, start_clr;
  logic [P_WORD_W-1:0] word;
  logic                word_vld;
  logic                unused_adc_hi;

  assign unused_adc_hi = ^adc_q;

`ifdef ADC_XOR_WHITEN_EN
  assign bits = adc_q[B-1:0] ^ adc_q[2*B-1:B];
`else
  assign bits = adc_q[B-1:0];
`endif

  always_ff @(posedge AD_CLK_P_SYS) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // stop outranks start everywhere except FAULT, where only start is honoured
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start && !stop) state_d = ST_WARMUP;
      ST_WARMUP:  if (stop) state_d = ST_IDLE;
                  else if (warm_cnt_q == WW'(P_WARMUP - 1)) state_d = ST_CAPTURE;
      ST_CAPTURE: if (stop) state_d = ST_IDLE;
                  else if (or_q && consec_q == OW'(P_OR_LIMIT - 1)) state_d = ST_FAULT;
      ST_FAULT:   if (start) state_d = ST_WARMUP;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
    fault     = (state_q == ST_FAULT);
    adc_oe_n  = !busy;
    bits_vld  = (state_q == ST_CAPTURE) && !stop && !or_q;
    flush     = (state_q != ST_CAPTURE) || stop;
    start_clr = (state_d == ST_WARMUP) && !busy;
  end

  adc_bit_packer #(
    .P_BITS   (B),
    .P_WORD_W (P_WORD_W)
  ) u_packer (
    .clk      (AD_CLK_P_SYS),
    .reset_n  (reset_n),
    .bits     (bits),
    .bits_vld (bits_vld),
    .flush    (flush),
    .word     (word),
    .word_vld (word_vld)
  );

  always_ff @(posedge AD_CLK_P_SYS) begin
    if (!reset_n) begin
      adc_q        <= '0;
      or_q         <= 1'b0;
      warm_cnt_q   <= '0;
      consec_q     <= '0;
      or_count_q   <= '0;
      drop_count_q <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      adc_q      <= adc_data;
      or_q       <= adc_or;
      warm_cnt_q <= (state_q == ST_WARMUP) ? warm_cnt_q + 1'b1 : '0;

      if (state_q != ST_CAPTURE) consec_q <= '0;
      else if (or_q)             consec_q <= consec_q + 1'b1;
      else                       consec_q <= '0;

      if (start_clr)                              or_count_q <= '0;
      else if (state_q == ST_CAPTURE && or_q && !stop) or_count_q <= sat_inc(or_count_q);

      // a completed word may only replace the held one in the cycle it is accepted
      if (word_vld && (!m_valid_q || m.m_ready)) begin
        m_data_q  <= word;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m.m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (start_clr)                                    drop_count_q <= '0;
      else if (word_vld && m_valid_q && !m.m_ready) drop_count_q <= sat_inc(drop_count_q);
    end
  end

  assign m.m_data   = m_data_q;
  assign m.m_valid  = m_valid_q;
  assign or_count   = or_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer (B=2, W=8, warm-up 4, OR limit 8, whitening off).
module tb_adc_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, adc_or;
  logic [13:0] adc_data;
  logic        adc_oe_n, busy, fault;
  logic [15:0] or_count, drop_count;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  adc_capture_sequencer_if #(.WORD_W(8)) m_if ();

  adc_capture_sequencer #(
    .P_BITS_PER_SAMPLE (2),
    .P_WORD_W          (8),
    .P_WARMUP          (4),
    .P_OR_LIMIT        (8)
  ) dut (
    .AD_CLK_P_SYS (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .adc_data     (adc_data),
    .adc_or       (adc_or),
    .adc_oe_n     (adc_oe_n),
    .m            (m_if),
    .busy         (busy),
    .fault        (fault),
    .or_count     (or_count),
    .drop_count   (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one sample, then land 1 time unit after the next rising edge
  task automatic tick(input logic [13:0] d, input logic o);
    adc_data = d;
    adc_or   = o;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 3; i >= 0; i--) tick({12'hA5C ^ 12'(i), w[2*i +: 2]}, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; adc_or = 1'b0; adc_data = '0;
    m_if.m_ready = 1'b1;

    // 1: reset
    repeat (3) tick(14'h0, 1'b0);
    check("rst_oe_n", adc_oe_n, 1);
    check("rst_valid", m_if.m_valid, 0);
    check("rst_data", m_if.m_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_or_cnt", or_count, 0);
    check("rst_drop_cnt", drop_count, 0);
    reset_n = 1'b1;
    tick(14'h0, 1'b0);
    check("idle_busy", busy, 0);

    // 2: incrementing samples, warm-up discard, first word
    start = 1'b1; tick(14'd0, 1'b0); start = 1'b0;
    check("start_oe_n", adc_oe_n, 0);
    check("start_busy", busy, 1);
    for (int k = 1; k <= 7; k++) tick(14'(k), 1'b0);
    check("latency_n1_valid", m_if.m_valid, 0);
    tick(14'd8, 1'b0);
    check("first_word_valid", m_if.m_valid, 1);
    check("first_word_data", m_if.m_data, 8'h1B);
    tick(14'd9, 1'b0);
    check("valid_clear_on_xfer", m_if.m_valid, 0);
    tick(14'd10, 1'b0);
    tick(14'd11, 1'b0);

    // 3: backpressure
    push_word(8'hA5);
    m_if.m_ready = 1'b0;
    push_word(8'h3C);
    check("held_valid", m_if.m_valid, 1);
    check("held_data", m_if.m_data, 8'hA5);
    push_word(8'hC3);
    check("held_data_2", m_if.m_data, 8'hA5);
    check("drop_cnt_1", drop_count, 1);

    // 4: over-range supervision
    tick(14'h0, 1'b1);
    check("drop_cnt_2", drop_count, 2);
    check("held_data_3", m_if.m_data, 8'hA5);
    check("held_valid_3", m_if.m_valid, 1);
    m_if.m_ready = 1'b1;
    tick(14'h0, 1'b1);
    check("held_released", m_if.m_valid, 0);
    tick(14'h0, 1'b1);
    tick(14'h3, 1'b0);
    check("or_cnt_3", or_count, 3);
    check("no_fault_3", fault, 0);
    repeat (8) tick(14'h0, 1'b1);
    check("no_fault_7_consec", fault, 0);
    check("or_cnt_10", or_count, 10);
    tick(14'h0, 1'b0);
    check("fault_set", fault, 1);
    check("fault_oe_n", adc_oe_n, 1);
    check("fault_busy", busy, 0);
    check("or_cnt_11", or_count, 11);
    check("fault_no_valid", m_if.m_valid, 0);
    stop = 1'b1; tick(14'h0, 1'b0); stop = 1'b0;
    check("fault_ignores_stop", fault, 1);
    start = 1'b1; tick(14'h3FFF, 1'b0); start = 1'b0;
    check("restart_fault_clr", fault, 0);
    check("restart_busy", busy, 1);
    check("restart_oe_n", adc_oe_n, 0);
    check("restart_or_clr", or_count, 0);
    check("restart_drop_clr", drop_count, 0);

    // 5: stop mid-word, then aligned restart
    repeat (3) tick(14'h3FFF, 1'b0);
    tick(14'd1, 1'b0);
    tick(14'd2, 1'b0);
    stop = 1'b1; tick(14'd3, 1'b0); stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_oe_n", adc_oe_n, 1);
    repeat (6) tick(14'h1, 1'b0);
    check("stop_no_valid", m_if.m_valid, 0);
    start = 1'b1; tick(14'h3FFF, 1'b0); start = 1'b0;
    repeat (3) tick(14'h3FFF, 1'b0);
    push_word(8'h96);
    m_if.m_ready = 1'b0;
    tick(14'h3FFF, 1'b0);
    check("aligned_valid", m_if.m_valid, 1);
    check("aligned_data", m_if.m_data, 8'h96);
    stop = 1'b1; tick(14'h0, 1'b0); stop = 1'b0;
    check("stop_keeps_busy0", busy, 0);
    check("stop_keeps_valid", m_if.m_valid, 1);
    check("stop_keeps_data", m_if.m_data, 8'h96);
    m_if.m_ready = 1'b1;
    tick(14'h0, 1'b0);
    check("held_drained", m_if.m_valid, 0);

    // 6: start+stop together in IDLE
    start = 1'b1; stop = 1'b1; tick(14'h0, 1'b0); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_oe_n", adc_oe_n, 1);
    tick(14'h0, 1'b0);
    check("startstop_idle", busy, 0);

    // warm-up ignores adc_or, then reset mid-operation
    start = 1'b1; tick(14'h0, 1'b1); start = 1'b0;
    repeat (7) tick(14'h0, 1'b1);
    check("warmup_ignores_or", or_count, 3);
    reset_n = 1'b0;
    tick(14'h0, 1'b0);
    check("midrst_busy", busy, 0);
    check("midrst_oe_n", adc_oe_n, 1);
    check("midrst_or_cnt", or_count, 0);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
